rle_decoder: RTL
================

RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 SHALL have parameter DBITS, default 8, data word width.
REQ-002 SHALL have parameter COUNT_BASE, default 48, ASCII offset of count byte ('0').
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, input byte FIFO depth (power of 2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of FIFO, FSM and flags.
REQ-007 SHALL have port in_data  input  DBITS  byte from UART receiver.
REQ-008 SHALL have port in_valid  input  1  one-cycle strobe, in_data valid.
REQ-009 SHALL have port in_ready  output  1  FIFO not full.
REQ-010 SHALL have port out_data  output  DBITS  expanded byte to UART transmitter.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  transmitter accepts out_data this cycle.
REQ-013 SHALL have port busy  output  1  FSM not in S_CNT or FIFO not empty.
REQ-014 SHALL have port err  output  1  sticky: invalid count byte seen.
REQ-015 SHALL have port ovf  output  1  sticky: byte dropped on full FIFO.
REQ-016 SHALL have port runs_done  output  8  runs fully emitted, wraps 255->0.

Function
REQ-017 Input stream SHALL be pairs {count, symbol}; run length = count - COUNT_BASE, 8-bit unsigned.
REQ-018 in_valid with FIFO not full SHALL push in_data; in_valid with FIFO full SHALL drop byte and set ovf.
REQ-019 in_ready SHALL reflect pre-pop fullness; push and pop on same cycle SHALL both occur when not full and not empty.
REQ-020 FSM states: S_CNT, S_SYM, S_EMIT.
REQ-021 S_CNT, FIFO non-empty: pop, latch remaining = count-COUNT_BASE, set bad = (count <= COUNT_BASE), go S_SYM.
REQ-022 S_SYM, FIFO non-empty: pop symbol; if bad, set err, discard, go S_CNT; else latch out_data, go S_EMIT.
REQ-023 S_EMIT: out_valid=1; on out_ready, decrement remaining; at last byte (remaining==1) increment runs_done, go S_CNT.
REQ-024 out_data/out_valid SHALL be registered; first out_valid on cycle after symbol pop.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Maximum run (count 0xFF) SHALL emit 255-COUNT_BASE = 207 bytes.
REQ-027 clear SHALL empty FIFO, return FSM to S_CNT, drop out_valid, clear err, ovf, runs_done; in_valid same cycle SHALL be ignored.

Reset
REQ-028 reset low SHALL immediately force: S_CNT, FIFO empty, out_valid=0, out_data=0, err=0, ovf=0, runs_done=0, in_ready=1, busy=0.
REQ-029 Reset mid-emit SHALL abandon the run; no further bytes of it after release.

Configuration
REQ-030 With RLE_DECODER_STATS_EN defined, SHALL add output bytes_out (16 bits, wraps) counting accepted out bytes, cleared by reset/clear.
REQ-031 Without RLE_DECODER_STATS_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package rle_pkg SHALL hold COUNT_BASE default, DBITS default and FSM state enum, shared with the encoder.
REQ-033 Input buffering SHALL be sub-module rle_byte_fifo (synchronous, registered full/empty).

Verification
REQ-034 Push '3','A', out_ready=1 -> out_data 0x41 on 3 consecutive cycles, runs_done=1, err=0.
REQ-035 Push '1','B','2','C' -> B,C,C, runs_done=2.
REQ-036 Push '0','D' then '1','E' -> err=1, no D output, then E emitted; alignment kept.
REQ-037 out_ready=0, push 0xFF,'Z' then 17 bytes -> 17th dropped, ovf=1; release -> 207 'Z'.
REQ-038 Assert reset low mid-run of '9','Q' after 4 bytes -> out_valid=0 same cycle; no further Q after release.
REQ-039 clear while in S_EMIT with err=1 -> out_valid=0 next cycle, err=0, FIFO empty, busy=0.

Source files
------------

// File: rtl/rle_pkg.sv
// rle_pkg: constants and FSM state encoding shared by the RLE encoder and decoder.
// Contents: default data width, ASCII count offset, FSM state enum, run-length helper.
// Configuration macros: none.
package rle_pkg;

  localparam int RLE_DBITS      = 8;
  localparam int RLE_COUNT_BASE = 48;  // ASCII '0'

  typedef enum logic [1:0] {
    S_CNT  = 2'd0,
    S_SYM  = 2'd1,
    S_EMIT = 2'd2
  } rle_state_e;

  // Run length carried by a count byte; 8-bit unsigned, wraps for counts below base.
  function automatic logic [7:0] run_len(input logic [7:0] cnt, input logic [7:0] base);
    return cnt - base;
  endfunction

endpackage

// File: rtl/rle_byte_fifo.sv
// rle_byte_fifo: synchronous byte FIFO with registered full/empty flags.
// Latency: pushed word readable on pop_data the cycle after the push; pop_data is combinational from rd pointer.
// Backpressure: push ignored while full, pop ignored while empty; clear flushes and ignores same-cycle push/pop.
// Ports: clk, reset (async active-low), clear, push/push_data, pop/pop_data, full, empty.
module rle_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q && !clear;
  assign do_pop  = pop && !empty_q && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end
    // Flags are computed from the next count so they can be registered.
    full_d  = (cnt_d == (AW+1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the flags guarantee unwritten entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/rle_decoder.sv
// rle_decoder: expands {count, symbol} byte pairs into runs of symbol bytes (count offset by COUNT_BASE).
// Latency: first output byte registered one cycle after the symbol pop; count and symbol pops take one cycle each.
// Backpressure: out_ready=0 holds out_data/out_valid; input FIFO absorbs bytes, drops on full and flags ovf.
// Ports: clk, reset (async active-low), clear (sync flush), in_data/in_valid/in_ready,
//        out_data/out_valid/out_ready, busy, err (sticky), ovf (sticky), runs_done (8-bit wrap).
// Configuration: define RLE_DECODER_STATS_EN to add bytes_out, a 16-bit count of accepted output bytes.
module rle_decoder
  import rle_pkg::*;
#(
  parameter int DBITS      = RLE_DBITS,
  parameter int COUNT_BASE = RLE_COUNT_BASE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err,
  output logic             ovf,
  output logic [7:0]       runs_done
`ifdef RLE_DECODER_STATS_EN
  ,
  output logic [15:0]      bytes_out
`endif
);

  rle_state_e       state_q, state_d;
  logic [7:0]       remaining_q, remaining_d;
  logic             bad_q, bad_d;
  logic [DBITS-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       runs_done_q, runs_done_d;

  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [DBITS-1:0] fifo_data;

  assign fifo_push = in_valid && !clear;

  rle_byte_fifo #(
    .WIDTH (DBITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_CNT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_CNT;
    end else begin
      case (state_q)
        S_CNT:   if (!fifo_empty) state_d = S_SYM;
        S_SYM:   if (!fifo_empty) state_d = bad_q ? S_CNT : S_EMIT;
        S_EMIT:  if (out_ready && remaining_q == 8'd1) state_d = S_CNT;
        default: state_d = S_CNT;
      endcase
    end
  end

  // Output and datapath logic.
  always_comb begin
    fifo_pop    = 1'b0;
    remaining_d = remaining_q;
    bad_d       = bad_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    runs_done_d = runs_done_q;
    if (clear) begin
      remaining_d = '0;
      bad_d       = 1'b0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      ovf_d       = 1'b0;
      runs_done_d = '0;
    end else begin
      // in_ready reflects pre-pop fullness, so a byte arriving on a full FIFO is lost
      // even when the FSM pops in the same cycle.
      if (in_valid && fifo_full) ovf_d = 1'b1;
      case (state_q)
        S_CNT: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            remaining_d = run_len(fifo_data[7:0], 8'(COUNT_BASE));
            // Zero or negative run lengths poison the pair; the symbol is still consumed
            // so the stream stays pair-aligned.
            bad_d       = (fifo_data <= DBITS'(COUNT_BASE));
          end
        end
        S_SYM: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (bad_q) begin
              err_d = 1'b1;
            end else begin
              out_data_d  = fifo_data;
              out_valid_d = 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              out_valid_d = 1'b0;
              runs_done_d = runs_done_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q <= '0;
      bad_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      runs_done_q <= '0;
    end else begin
      remaining_q <= remaining_d;
      bad_q       <= bad_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      runs_done_q <= runs_done_d;
    end
  end

`ifdef RLE_DECODER_STATS_EN
  logic [15:0] bytes_out_q, bytes_out_d;

  always_comb begin
    bytes_out_d = bytes_out_q;
    if (clear)                           bytes_out_d = '0;
    else if (out_valid_q && out_ready)   bytes_out_d = bytes_out_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bytes_out_q <= '0;
    else        bytes_out_q <= bytes_out_d;
  end

  assign bytes_out = bytes_out_q;
`endif

  assign in_ready  = !fifo_full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_CNT) || !fifo_empty;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign runs_done = runs_done_q;

endmodule
